casex_classifier: RTL and testbench

Parametrised, pipelined masked-pattern classifier: each accepted input word is compared against a programmable table of value/mask rules with casex-style don't-care semantics, and the lowest-index matching rule wins. The result (hit flag, rule index, original data) is delivered on a registered valid/ready output, and per-rule saturating hit counters plus a miss counter are maintained. The block sits between a data source and downstream dispatch logic, and replaces fixed hard-coded pattern decoders.

---
 rtl/casex_classifier.sv | 163 ++++++++++++++++
 tb/tb_casex_classifier.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/casex_classifier.sv
// ============================================================================
// Module   : casex_classifier
// Purpose  : value/mask rule classifier (lowest index wins) with hit/miss
//            counters; CASEX_CLASSIFIER_DISPLAY_EN adds a simulation log.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module casex_classifier #(
  parameter int WIDTH = 3,
  parameter int RULES = 4,
  parameter int CNT_W = 8,
  parameter int IDX_W = $clog2(RULES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [WIDTH-1:0] cfg_value,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_hit,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] out_data,
  input  logic [IDX_W:0]   cnt_sel,
  output logic [CNT_W-1:0] cnt_value,
  input  logic             cnt_clr
);

  localparam int               c_NCNT    = RULES + 1;
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [WIDTH-1:0] r_value [RULES];
  logic [WIDTH-1:0] r_mask  [RULES];
  logic [RULES-1:0] r_en;

  logic [RULES-1:0]  w_match;
  logic              w_hit;
  logic [IDX_W-1:0]  w_idx;
  logic              w_xfer_in;
  logic [c_NCNT-1:0] w_inc;

  logic [CNT_W-1:0]  r_cnt [c_NCNT];

  logic              r_out_valid;
  logic              r_out_hit;
  logic [IDX_W-1:0]  r_out_idx;
  logic [WIDTH-1:0]  r_out_data;

  // Slot compare only ever equals an in-range index, so out-of-range writes drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < RULES; r++) begin
        r_value[r] <= '0;
        r_mask[r]  <= '0;
      end
      r_en <= '0;
    end else if (cfg_we) begin
      for (int r = 0; r < RULES; r++) begin
        if (cfg_idx == IDX_W'(r)) begin
          r_value[r] <= cfg_value;
          r_mask[r]  <= cfg_mask;
          r_en[r]    <= cfg_en;
        end
      end
    end
  end

  generate
    for (genvar r = 0; r < RULES; r++) begin : g_match
      assign w_match[r] = r_en[r] && (((in_data ^ r_value[r]) & ~r_mask[r]) == '0);
    end
  endgenerate

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int r = RULES - 1; r >= 0; r--) begin
      if (w_match[r]) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(r);
      end
    end
  end

  assign in_ready  = !r_out_valid || out_ready;
  assign w_xfer_in = in_valid && in_ready;

  always_comb begin
    w_inc = '0;
    for (int k = 0; k < RULES; k++) begin
      w_inc[k] = w_xfer_in && w_hit && (w_idx == IDX_W'(k));
    end
    w_inc[RULES] = w_xfer_in && !w_hit;
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      for (int k = 0; k < c_NCNT; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < c_NCNT; k++) begin
        if (w_inc[k] && (r_cnt[k] != c_CNT_MAX)) begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    cnt_value = '0;
    for (int k = 0; k < c_NCNT; k++) begin
      if (cnt_sel == (IDX_W + 1)'(k)) begin
        cnt_value = r_cnt[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_hit   <= 1'b0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
    end else if (w_xfer_in) begin
      r_out_valid <= 1'b1;
      r_out_hit   <= w_hit;
      r_out_idx   <= w_idx;
      r_out_data  <= in_data;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_hit   = r_out_hit;
  assign out_idx   = r_out_idx;
  assign out_data  = r_out_data;

`ifdef CASEX_CLASSIFIER_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (!rst && w_xfer_in) begin
      if (w_hit) begin
        $display("rule%0d:c=%b", w_idx, in_data);
      end else begin
        $display("miss:c=%b", in_data);
      end
    end
  end
`else
  // Default build: classification log compiled out.
`endif

endmodule

`default_nettype wire

// File: tb/tb_casex_classifier.sv
// ============================================================================
// Module   : tb_casex_classifier
// Purpose  : directed self-checking bench for casex_classifier (CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_casex_classifier;

  localparam int WIDTH = 3;
  localparam int RULES = 4;
  localparam int CNT_W = 2;
  localparam int IDX_W = 2;

  logic             clk;
  logic             rst;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [WIDTH-1:0] cfg_value;
  logic [WIDTH-1:0] cfg_mask;
  logic             cfg_en;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_hit;
  logic [IDX_W-1:0] out_idx;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W:0]   cnt_sel;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_clr;

  int n_tests = 0;
  int n_fail  = 0;

  casex_classifier #(
    .WIDTH(WIDTH),
    .RULES(RULES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_value(cfg_value),
    .cfg_mask(cfg_mask), .cfg_en(cfg_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_idx(out_idx), .out_data(out_data),
    .cnt_sel(cnt_sel), .cnt_value(cnt_value), .cnt_clr(cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int sel, input int exp);
    cnt_sel = (IDX_W + 1)'(sel);
    #1;
    chk(tag, 32'(cnt_value), 32'(exp));
  endtask

  task automatic chk_out(input string tag, input logic v, input logic h,
                         input int idx, input int data);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".hit"},   32'(out_hit),   32'(h));
    chk({tag, ".idx"},   32'(out_idx),   32'(idx));
    chk({tag, ".data"},  32'(out_data),  32'(data));
  endtask

  task automatic cfg(input int idx, input int val, input int mask, input logic en);
    cfg_we    = 1'b1;
    cfg_idx   = IDX_W'(idx);
    cfg_value = WIDTH'(val);
    cfg_mask  = WIDTH'(mask);
    cfg_en    = en;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic send(input int data);
    in_valid  = 1'b1;
    in_data   = WIDTH'(data);
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  // Stream words 000..111 against rules r0=000/001, r1=100/000, r2=001/000.
  logic [WIDTH-1:0] stream_hit_map [8];
  int               stream_idx_map [8];

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_value = '0; cfg_mask = '0;
    cfg_en = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cnt_sel = '0; cnt_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk_out("reset", 1'b0, 1'b0, 0, 0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k <= RULES; k++) chk_cnt("reset.cnt", k, 0);

    // Overlap priority
    cfg(0, 3'b000, 3'b001, 1'b1);
    cfg(1, 3'b100, 3'b000, 1'b1);
    cfg(2, 3'b001, 3'b000, 1'b1);
    send(3'b000); chk_out("prio.000", 1'b1, 1'b1, 0, 3'b000);
    send(3'b001); chk_out("prio.001", 1'b1, 1'b1, 0, 3'b001);
    send(3'b100); chk_out("prio.100", 1'b1, 1'b1, 1, 3'b100);
    send(3'b111); chk_out("prio.111", 1'b1, 1'b0, 0, 3'b111);
    chk_cnt("prio.cnt0", 0, 2);
    chk_cnt("prio.cnt1", 1, 1);
    chk_cnt("prio.cnt2", 2, 0);
    chk_cnt("prio.cnt3", 3, 0);
    chk_cnt("prio.miss", 4, 1);
    chk_cnt("prio.sel5", 5, 0);
    tick();
    chk("prio.drain", 32'(out_valid), 32'd0);

    // Backpressure
    clear_cnt();
    in_valid = 1'b1; in_data = 3'b001; out_ready = 1'b0;
    tick();
    in_data = 3'b100;
    for (int c = 0; c < 5; c++) begin
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk_out("bp.hold", 1'b1, 1'b1, 0, 3'b001);
      tick();
    end
    chk_cnt("bp.cnt1", 1, 0);
    stream_hit_map = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    stream_idx_map = '{0, 0, 0, 0, 1, 0, 0, 0};
    out_ready = 1'b1;
    for (int w = 0; w < 8; w++) begin
      in_data = WIDTH'(w);
      #1;
      chk("bp.stream_ready", 32'(in_ready), 32'd1);
      tick();
      chk_out("bp.stream", 1'b1, stream_hit_map[w][0], stream_idx_map[w], w);
    end
    in_valid = 1'b0;
    tick();
    chk("bp.drain", 32'(out_valid), 32'd0);
    chk_cnt("bp.cnt1b", 1, 1);

    // Saturation and clear
    clear_cnt();
    for (int n = 1; n <= 5; n++) begin
      send(3'b000);
      chk_cnt("sat.cnt0", 0, (n > 3) ? 3 : n);
    end
    in_valid = 1'b1; in_data = 3'b000; cnt_clr = 1'b1;
    tick();
    in_valid = 1'b0; cnt_clr = 1'b0;
    chk_out("sat.clr_out", 1'b1, 1'b1, 0, 3'b000);
    chk_cnt("sat.clr_cnt0", 0, 0);

    // Config race: rule1 repurposed to 011, enabled in the accepting cycle
    cfg(1, 3'b011, 3'b000, 1'b0);
    in_valid = 1'b1; in_data = 3'b011; out_ready = 1'b1;
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_value = 3'b011; cfg_mask = 3'b000; cfg_en = 1'b1;
    tick();
    cfg_we = 1'b0;
    chk_out("race.old", 1'b1, 1'b0, 0, 3'b011);
    tick();
    in_valid = 1'b0;
    chk_out("race.new", 1'b1, 1'b1, 1, 3'b011);

    // All-ones mask on rule3 catches everything lower rules miss
    cfg(3, 3'b000, 3'b111, 1'b1);
    send(3'b110); chk_out("mask.110", 1'b1, 1'b1, 3, 3'b110);
    chk_cnt("mask.cnt3", 3, 1);
    chk_cnt("mask.miss", 4, 1);
    chk_cnt("mask.sel7", 7, 0);

    // Reset mid-stream
    in_valid = 1'b1; in_data = 3'b000; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("rst.pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst.valid", 32'(out_valid), 32'd0);
    for (int k = 0; k <= RULES; k++) chk_cnt("rst.cnt", k, 0);
    send(3'b000);
    chk_out("rst.miss", 1'b1, 1'b0, 0, 3'b000);
    chk_cnt("rst.miss_cnt", 4, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
